ahb_mem_slave: RTL and testbench

AHB-Lite responder that terminates transfers issued by the bridge's AHB master, backed by an internal word-organised memory. It decodes a fixed address window, inserts a programmable number of wait states per data phase, performs byte/halfword/word writes on the correct byte lanes, and returns two-cycle ERROR responses for illegal accesses. It sits on the AHB side of the bridge as a standalone target for exercising single, INCR and WRAP traffic.

---
 rtl/ahb_mem_slave_if.sv | 22 ++
 rtl/ahb_mem_slave.sv | 123 ++++++++++++
 tb/tb_ahb_mem_slave.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite bus bundle between one master and the memory responder.
interface ahb_mem_slave_if;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [2:0]  Hsize;
  logic [31:0] Hwdata;
  logic        Hreadyin;
  logic        Hreadyout;
  logic        Hresp;
  logic [31:0] Hrdata;

  modport master (
    output Haddr, Htrans, Hwrite, Hsize, Hwdata, Hreadyin,
    input  Hreadyout, Hresp, Hrdata
  );

  modport slave (
    input  Haddr, Htrans, Hwrite, Hsize, Hwdata, Hreadyin,
    output Hreadyout, Hresp, Hrdata
  );
endinterface

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory responder: fixed window, WAIT_STATES wait cycles per OKAY beat, two-cycle ERROR.
// Latency: accept at edge N, data phase N..N+WAIT_STATES; backpressure via Hreadyout low in WAIT/ERR1.
module ahb_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 1
) (
  input  logic           Hclk,
  input  logic           Hresetn,
  ahb_mem_slave_if.slave bus
);
  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN_MASK = ~(32'(DEPTH_WORDS * 4) - 32'd1);
  localparam logic [2:0]  WS       = 3'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      wait_cnt, wait_cnt_nxt;
  logic [AW+1:0]   addr_q;
  logic            wr_q;
  logic [2:0]      size_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            can_accept;
  logic            accept;
  logic            bad_xfer;
  logic            commit;
  logic [AW-1:0]   idx;
  logic [3:0]      lanes;

  assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept     = can_accept && bus.Hreadyin && bus.Htrans[1];

  assign bad_xfer = ((bus.Haddr & WIN_MASK) != BASE_ADDR)
                 || (bus.Hsize > 3'd2)
                 || ((bus.Hsize == 3'd1) && bus.Haddr[0])
                 || ((bus.Hsize == 3'd2) && (bus.Haddr[1:0] != 2'b00));

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_WAIT: begin
        wait_cnt_nxt = wait_cnt - 3'd1;
        if (wait_cnt <= 3'd1) begin
          state_nxt    = S_DATA;
          wait_cnt_nxt = 3'd0;
        end
      end
      S_ERR1: state_nxt = S_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all end a data phase, so a pipelined beat is taken here
        if (accept) begin
          if (bad_xfer) begin
            state_nxt = S_ERR1;
          end else if (WS != 3'd0) begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = WS;
          end else begin
            state_nxt = S_DATA;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state    <= S_IDLE;
      wait_cnt <= 3'd0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      size_q   <= 3'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        addr_q <= bus.Haddr[AW+1:0];
        wr_q   <= bus.Hwrite;
        size_q <= bus.Hsize;
      end
    end
  end

  assign idx    = addr_q[AW+1:2];
  assign commit = (state == S_DATA) && wr_q;

  always_comb begin
    lanes = 4'b1111;
    case (size_q)
      3'd0:    lanes = 4'b0001 << addr_q[1:0];
      3'd1:    lanes = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) begin
          mem[idx][8*b +: 8] <= bus.Hwdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.Hreadyout = (state != S_WAIT) && (state != S_ERR1);
  assign bus.Hresp     = (state == S_ERR1) || (state == S_ERR2);
  assign bus.Hrdata    = ((state == S_DATA) && !wr_q) ? mem[idx] : 32'h0;
endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench: three responders (WAIT_STATES 1, 0, 3) on one shared stimulus bus, selected per test.
module tb_ahb_mem_slave;
  localparam logic [1:0] T_IDLE = 2'd0, T_NONSEQ = 2'd2, T_SEQ = 2'd3;

  logic        clk = 1'b0;
  logic [2:0]  rstn = 3'b111;
  int          sel = 0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = T_IDLE;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] hwdata = '0;

  int passed = 0;
  int total  = 0;

  logic [31:0] a_addr [8];
  logic [1:0]  a_trans[8];
  logic        a_wr   [8];
  logic [2:0]  a_size [8];
  logic [31:0] a_wdata[8];
  int          r_waits [8];
  logic        r_resp_w[8];
  logic        r_resp  [8];
  logic [31:0] r_rdata [8];

  always #5 clk = ~clk;

  ahb_mem_slave_if bus0 ();
  ahb_mem_slave_if bus1 ();
  ahb_mem_slave_if bus2 ();

  assign bus0.Haddr = haddr;  assign bus1.Haddr = haddr;  assign bus2.Haddr = haddr;
  assign bus0.Hwrite = hwrite; assign bus1.Hwrite = hwrite; assign bus2.Hwrite = hwrite;
  assign bus0.Hsize = hsize;  assign bus1.Hsize = hsize;  assign bus2.Hsize = hsize;
  assign bus0.Hwdata = hwdata; assign bus1.Hwdata = hwdata; assign bus2.Hwdata = hwdata;
  assign bus0.Htrans = (sel == 0) ? htrans : T_IDLE;
  assign bus1.Htrans = (sel == 1) ? htrans : T_IDLE;
  assign bus2.Htrans = (sel == 2) ? htrans : T_IDLE;
  assign bus0.Hreadyin = bus0.Hreadyout;
  assign bus1.Hreadyin = bus1.Hreadyout;
  assign bus2.Hreadyin = bus2.Hreadyout;

  ahb_mem_slave #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(64), .WAIT_STATES(1))
    dut0 (.Hclk(clk), .Hresetn(rstn[0]), .bus(bus0.slave));
  ahb_mem_slave #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(64), .WAIT_STATES(0))
    dut1 (.Hclk(clk), .Hresetn(rstn[1]), .bus(bus1.slave));
  ahb_mem_slave #(.BASE_ADDR(32'h8000_0000), .DEPTH_WORDS(64), .WAIT_STATES(3))
    dut2 (.Hclk(clk), .Hresetn(rstn[2]), .bus(bus2.slave));

  logic        cur_rdy, cur_resp;
  logic [31:0] cur_rdata;
  assign cur_rdy   = (sel == 0) ? bus0.Hreadyout : (sel == 1) ? bus1.Hreadyout : bus2.Hreadyout;
  assign cur_resp  = (sel == 0) ? bus0.Hresp     : (sel == 1) ? bus1.Hresp     : bus2.Hresp;
  assign cur_rdata = (sel == 0) ? bus0.Hrdata    : (sel == 1) ? bus1.Hrdata    : bus2.Hrdata;

  task automatic set_beat(input int i, input logic [31:0] addr, input logic [1:0] trans,
                          input logic wr, input logic [2:0] size, input logic [31:0] wdata);
    a_addr[i] = addr; a_trans[i] = trans; a_wr[i] = wr; a_size[i] = size; a_wdata[i] = wdata;
  endtask

  // Pipelined master: entered and left just after a rising edge.
  task automatic run_beats(input int n);
    int   ai = 0;
    int   di = -1;
    int   cyc = 0;
    logic rdy;
    for (int i = 0; i < 8; i++) begin
      r_waits[i] = 0; r_resp_w[i] = 1'b0; r_resp[i] = 1'b0; r_rdata[i] = '0;
    end
    while ((ai < n || di >= 0) && cyc < 100) begin
      haddr  = (ai < n) ? a_addr[ai]  : 32'h0;
      htrans = (ai < n) ? a_trans[ai] : T_IDLE;
      hwrite = (ai < n) ? a_wr[ai]    : 1'b0;
      hsize  = (ai < n) ? a_size[ai]  : 3'd0;
      hwdata = (di >= 0) ? a_wdata[di] : 32'h0;
      @(negedge clk);
      rdy = cur_rdy;
      if (di >= 0) begin
        if (!rdy) begin
          r_waits[di]++;
          r_resp_w[di] = r_resp_w[di] | cur_resp;
        end else begin
          r_resp[di]  = cur_resp;
          r_rdata[di] = cur_rdata;
        end
      end
      @(posedge clk); #1;
      if (rdy) begin
        di = (ai < n) ? ai : -1;
        if (ai < n) ai++;
      end
      cyc++;
    end
    htrans = T_IDLE;
    if (cyc >= 100) begin
      total++;
      $display("FAIL run_beats timeout: got %0d cycles, required fewer than 100", cyc);
    end
  endtask

  task automatic test_reset();
    rstn = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus0.Hreadyout !== 1'b1) $display("FAIL rst0_ready: got %b want 1", bus0.Hreadyout); else passed++;
    total++; if (bus0.Hresp !== 1'b0)     $display("FAIL rst0_resp: got %b want 0", bus0.Hresp); else passed++;
    total++; if (bus0.Hrdata !== 32'h0)   $display("FAIL rst0_rdata: got %h want 0", bus0.Hrdata); else passed++;
    total++; if (bus1.Hreadyout !== 1'b1) $display("FAIL rst1_ready: got %b want 1", bus1.Hreadyout); else passed++;
    total++; if (bus1.Hresp !== 1'b0)     $display("FAIL rst1_resp: got %b want 0", bus1.Hresp); else passed++;
    total++; if (bus1.Hrdata !== 32'h0)   $display("FAIL rst1_rdata: got %h want 0", bus1.Hrdata); else passed++;
    total++; if (bus2.Hreadyout !== 1'b1) $display("FAIL rst2_ready: got %b want 1", bus2.Hreadyout); else passed++;
    total++; if (bus2.Hresp !== 1'b0)     $display("FAIL rst2_resp: got %b want 0", bus2.Hresp); else passed++;
    total++; if (bus2.Hrdata !== 32'h0)   $display("FAIL rst2_rdata: got %h want 0", bus2.Hrdata); else passed++;
    rstn = 3'b111;
    @(posedge clk); #1;
  endtask

  task automatic test_wait_states();
    sel = 0;
    set_beat(0, 32'h8000_0001, T_NONSEQ, 1'b1, 3'd0, 32'h0000_8000);
    set_beat(1, 32'h8000_0000, T_NONSEQ, 1'b0, 3'd2, 32'h0);
    run_beats(2);
    total++; if (r_waits[0] !== 1) $display("FAIL ws1_wr_waits: got %0d want 1", r_waits[0]); else passed++;
    total++; if (r_waits[1] !== 1) $display("FAIL ws1_rd_waits: got %0d want 1", r_waits[1]); else passed++;
    total++; if (r_resp[0] !== 1'b0 || r_resp_w[0] !== 1'b0) $display("FAIL ws1_wr_resp: got %b/%b want 0/0", r_resp_w[0], r_resp[0]); else passed++;
    total++; if (r_resp[1] !== 1'b0 || r_resp_w[1] !== 1'b0) $display("FAIL ws1_rd_resp: got %b/%b want 0/0", r_resp_w[1], r_resp[1]); else passed++;
    total++; if (r_rdata[1] !== 32'h0000_8000) $display("FAIL ws1_rdata: got %h want 00008000", r_rdata[1]); else passed++;
  endtask

  task automatic test_errors();
    sel = 0;
    set_beat(0, 32'h8000_0100, T_NONSEQ, 1'b1, 3'd2, 32'hFFFF_FFFF);
    set_beat(1, 32'h8000_0000, T_NONSEQ, 1'b0, 3'd2, 32'h0);
    run_beats(2);
    total++; if (r_waits[0] !== 1) $display("FAIL oob_waits: got %0d want 1", r_waits[0]); else passed++;
    total++; if (r_resp_w[0] !== 1'b1) $display("FAIL oob_resp_first: got %b want 1", r_resp_w[0]); else passed++;
    total++; if (r_resp[0] !== 1'b1) $display("FAIL oob_resp_last: got %b want 1", r_resp[0]); else passed++;
    total++; if (r_rdata[1] !== 32'h0000_8000) $display("FAIL oob_rd_after: got %h want 00008000", r_rdata[1]); else passed++;

    set_beat(0, 32'h8000_0002, T_NONSEQ, 1'b1, 3'd2, 32'h1234_5678);
    set_beat(1, 32'h8000_0000, T_NONSEQ, 1'b1, 3'd3, 32'h1234_5678);
    set_beat(2, 32'h8000_0000, T_NONSEQ, 1'b0, 3'd2, 32'h0);
    run_beats(3);
    total++; if (r_waits[0] !== 1 || r_resp_w[0] !== 1'b1 || r_resp[0] !== 1'b1)
      $display("FAIL misalign_err: got waits %0d resp %b/%b want 1 1/1", r_waits[0], r_resp_w[0], r_resp[0]); else passed++;
    total++; if (r_waits[1] !== 1 || r_resp_w[1] !== 1'b1 || r_resp[1] !== 1'b1)
      $display("FAIL size3_err: got waits %0d resp %b/%b want 1 1/1", r_waits[1], r_resp_w[1], r_resp[1]); else passed++;
    total++; if (r_rdata[2] !== 32'h0000_8000) $display("FAIL err_mem_kept: got %h want 00008000", r_rdata[2]); else passed++;
    total++; if (r_resp[2] !== 1'b0) $display("FAIL err_then_okay: got %b want 0", r_resp[2]); else passed++;
  endtask

  task automatic test_incr4();
    int sum;
    sel = 1;
    set_beat(0, 32'h8000_0010, T_NONSEQ, 1'b1, 3'd0, 32'h0000_0011);
    set_beat(1, 32'h8000_0011, T_SEQ,    1'b1, 3'd0, 32'h0000_2200);
    set_beat(2, 32'h8000_0012, T_SEQ,    1'b1, 3'd0, 32'h0033_0000);
    set_beat(3, 32'h8000_0013, T_SEQ,    1'b1, 3'd0, 32'h4400_0000);
    set_beat(4, 32'h8000_0010, T_NONSEQ, 1'b0, 3'd2, 32'h0);
    run_beats(5);
    sum = 0;
    for (int i = 0; i < 5; i++) sum += r_waits[i];
    total++; if (sum !== 0) $display("FAIL incr4_waits: got %0d want 0", sum); else passed++;
    total++; if (r_rdata[4] !== 32'h4433_2211) $display("FAIL incr4_rdata: got %h want 44332211", r_rdata[4]); else passed++;
  endtask

  task automatic test_wrap4();
    sel = 1;
    set_beat(0, 32'h8000_004A, T_NONSEQ, 1'b1, 3'd1, 32'hAAAA_0000);
    set_beat(1, 32'h8000_004C, T_SEQ,    1'b1, 3'd1, 32'h0000_BBBB);
    set_beat(2, 32'h8000_004E, T_SEQ,    1'b1, 3'd1, 32'hCCCC_0000);
    set_beat(3, 32'h8000_0048, T_SEQ,    1'b1, 3'd1, 32'h0000_DDDD);
    set_beat(4, 32'h8000_0048, T_NONSEQ, 1'b0, 3'd2, 32'h0);
    set_beat(5, 32'h8000_004C, T_SEQ,    1'b0, 3'd2, 32'h0);
    set_beat(6, 32'h8000_0001, T_NONSEQ, 1'b1, 3'd1, 32'hFFFF_FFFF);
    run_beats(7);
    total++; if (r_rdata[4] !== 32'hAAAA_DDDD) $display("FAIL wrap4_rd48: got %h want aaaadddd", r_rdata[4]); else passed++;
    total++; if (r_rdata[5] !== 32'hCCCC_BBBB) $display("FAIL wrap4_rd4c: got %h want ccccbbbb", r_rdata[5]); else passed++;
    total++; if (r_waits[6] !== 1 || r_resp_w[6] !== 1'b1 || r_resp[6] !== 1'b1)
      $display("FAIL ws0_half_err: got waits %0d resp %b/%b want 1 1/1", r_waits[6], r_resp_w[6], r_resp[6]); else passed++;
  endtask

  task automatic test_back_to_back();
    sel = 1;
    set_beat(0, 32'h8000_0000, T_NONSEQ, 1'b1, 3'd2, 32'hCAFE_F00D);
    set_beat(1, 32'h8000_0000, T_NONSEQ, 1'b0, 3'd2, 32'h0);
    run_beats(2);
    total++; if (r_rdata[1] !== 32'hCAFE_F00D) $display("FAIL raw_rdata: got %h want cafef00d", r_rdata[1]); else passed++;
  endtask

  task automatic test_reset_mid();
    sel = 2;
    haddr = 32'h8000_0020; htrans = T_NONSEQ; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    htrans = T_IDLE; hwdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (cur_rdy !== 1'b0) $display("FAIL rstmid_wait1: got %b want 0", cur_rdy); else passed++;
    @(posedge clk); #1;
    rstn[2] = 1'b0;
    @(posedge clk); #1;
    rstn[2] = 1'b1;
    @(negedge clk);
    total++; if (cur_rdy !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", cur_rdy); else passed++;
    total++; if (cur_resp !== 1'b0) $display("FAIL rstmid_resp: got %b want 0", cur_resp); else passed++;
    @(posedge clk); #1;
    set_beat(0, 32'h8000_0020, T_NONSEQ, 1'b0, 3'd2, 32'h0);
    run_beats(1);
    total++; if (r_waits[0] !== 3) $display("FAIL ws3_waits: got %0d want 3", r_waits[0]); else passed++;
    total++; if (r_rdata[0] !== 32'h0) $display("FAIL rstmid_rdata: got %h want 0", r_rdata[0]); else passed++;
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_errors();
    test_incr4();
    test_wrap4();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
